rib_dma: RTL and testbench
==========================

RIB_DMA -- requirements
Module: rib_dma

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports addr_i input 32, data_i input 32, data_o output 32, we_i input 1: config slave port, single-cycle, no req/ready.
REQ-004 SHALL have ports m_addr_o output 32, m_data_o output 32, m_data_i input 32, m_req_o output 1, m_we_o output 1: bus master port, wired to a highest-priority master slot without ready.
REQ-005 SHALL have port irq_o, output, 1, level interrupt: done or error with IRQ_EN set.

Function
REQ-006 SHALL decode config registers on addr_i[4:2]: 0 SRC, 1 DST, 2 LEN[15:0] in words, 3 CTRL (bit0 START, bit1 IRQ_EN), 4 STATUS (bit0 BUSY, bit1 DONE, bit2 ERR); other offsets read 0, writes ignored.
REQ-007 SHALL return data_o combinationally from addr_i; CTRL.START reads 0.
REQ-008 SHALL ignore writes to SRC, DST, LEN, CTRL.START while BUSY=1; IRQ_EN stays writable.
REQ-009 SHALL clear DONE and ERR on any write to STATUS, irrespective of write data.
REQ-010 SHALL use FSM states IDLE, READ, WRITE, FINISH.
REQ-011 IDLE: START write with LEN!=0 -> READ, BUSY=1, DONE=ERR=0; START with LEN=0 -> FINISH (no bus cycles).
REQ-012 READ: m_req_o=1, m_we_o=0, m_addr_o=current src; m_data_i latched into word buffer at clock edge (same-cycle read data) -> WRITE.
REQ-013 WRITE: m_req_o=1, m_we_o=1, m_addr_o=current dst, m_data_o=buffer; at edge src+=4, dst+=4, remaining-=1; remaining reaching 0 -> FINISH, else READ.
REQ-014 SHALL leave m_req_o=0 and m_addr_o, m_data_o, m_we_o=0 outside READ/WRITE.
REQ-015 FINISH: one cycle, BUSY=0, DONE=1 -> IDLE.
REQ-016 SHALL check, before each READ/WRITE cycle, that address[31:28] <= 4'h5 and address[1:0]==0; on violation SHALL issue no bus cycle, set ERR=1, BUSY=0, go IDLE; DONE stays 0.
REQ-017 SHALL wrap src/dst modulo 2^32 without error; wrap into an illegal region is caught by REQ-016.
REQ-018 One word transfer SHALL take exactly 2 cycles; LEN=N SHALL complete in 2N+1 cycles from START write edge to DONE=1.
REQ-019 irq_o SHALL equal IRQ_EN & (DONE | ERR), registered-state derived, glitch-free.
REQ-020 SHALL keep SRC/DST/LEN registers unchanged by transfer; working copies are internal.

Reset
REQ-021 On rst=1: FSM IDLE; SRC, DST, LEN, CTRL, STATUS, buffer, counters = 0; m_req_o=0, m_we_o=0, irq_o=0, immediately and asynchronously.
REQ-022 Reset mid-transfer SHALL abort with no further bus cycle; no partial DONE.

Structure
REQ-023 Register offsets, CTRL/STATUS bit positions and FSM state enum SHALL live in tinyriscv_pkg; widths use MemAddrBus/MemBus.
REQ-024 SHALL be a single module; the register file and the FSM are not split into sub-modules.

Verification
REQ-025 SRC=0x1000_0000, DST=0x1000_0100, LEN=3, START -> six alternating cycles read/write at 0x..00/0x..100, 0x..04/0x..104, 0x..08/0x..108; DONE=1 after 7 cycles.
REQ-026 LEN=0, START -> no m_req_o, DONE=1 next cycle.
REQ-027 DST=0x7000_0000, LEN=1, IRQ_EN=1 -> one READ, no WRITE, ERR=1, irq_o=1; STATUS write -> irq_o=0.
REQ-028 Write SRC=0x2000_0000 during BUSY -> readback shows original SRC; transfer unaffected.
REQ-029 rst pulse during 2nd WRITE of LEN=4 -> m_req_o=0 same cycle, all registers 0, no later bus activity.
REQ-030 SRC=0x5FFF_FFFC, LEN=2 -> first word transferred, second READ at 0x6000_0000 rejected, ERR=1.

Source files
------------

// File: rtl/tinyriscv_pkg.sv
// Shared definitions for the RIB DMA engine: bus widths, register map,
// control/status bit positions, FSM states and the address legality rule.
package tinyriscv_pkg;

    localparam int MemAddrBus = 32;
    localparam int MemBus     = 32;
    localparam int DmaLenW    = 16;

    // Config register offsets, decoded from addr_i[4:2]
    typedef enum logic [2:0] {
        REG_SRC    = 3'd0,
        REG_DST    = 3'd1,
        REG_LEN    = 3'd2,
        REG_CTRL   = 3'd3,
        REG_STATUS = 3'd4
    } dma_reg_e;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_READ,
        DMA_WRITE,
        DMA_FINISH
    } dma_state_e;

    localparam logic [3:0] DMA_MAX_REGION = 4'h5;

    // Legal DMA targets: word aligned and within regions 0x0..0x5
    function automatic logic dma_addr_ok(input logic [MemAddrBus-1:0] a);
        return (a[MemAddrBus-1:MemAddrBus-4] <= DMA_MAX_REGION) && (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rib_dma.sv
// Single-channel word-copy DMA: config slave register file plus a
// read/write FSM driving a highest-priority RIB master slot.
module rib_dma
    import tinyriscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic [MemAddrBus-1:0] addr_i,
    input  logic [MemBus-1:0]     data_i,
    output logic [MemBus-1:0]     data_o,
    input  logic                  we_i,

    output logic [MemAddrBus-1:0] m_addr_o,
    output logic [MemBus-1:0]     m_data_o,
    input  logic [MemBus-1:0]     m_data_i,
    output logic                  m_req_o,
    output logic                  m_we_o,

    output logic                  irq_o
);

    dma_state_e state_q, state_n;

    logic [MemAddrBus-1:0] src_q, src_n;
    logic [MemAddrBus-1:0] dst_q, dst_n;
    logic [DmaLenW-1:0]    len_q, len_n;
    logic                  irq_en_q, irq_en_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
    logic                  err_q, err_n;

    logic [MemAddrBus-1:0] cur_src_q, cur_src_n;
    logic [MemAddrBus-1:0] cur_dst_q, cur_dst_n;
    logic [DmaLenW-1:0]    rem_q, rem_n;
    logic [MemBus-1:0]     buf_q, buf_n;
    logic                  irq_q, irq_n;

    logic [2:0] reg_sel;
    logic       wr_src, wr_dst, wr_len, wr_ctrl, wr_status;
    logic       start_req;
    logic       unused_addr;

    assign reg_sel     = addr_i[4:2];
    assign unused_addr = ^{addr_i[MemAddrBus-1:5], addr_i[1:0]};

    assign wr_src    = we_i && (reg_sel == REG_SRC);
    assign wr_dst    = we_i && (reg_sel == REG_DST);
    assign wr_len    = we_i && (reg_sel == REG_LEN);
    assign wr_ctrl   = we_i && (reg_sel == REG_CTRL);
    assign wr_status = we_i && (reg_sel == REG_STATUS);
    assign start_req = wr_ctrl && data_i[CTRL_START] && (state_q == DMA_IDLE);

    always_comb begin
        data_o = '0;
        case (reg_sel)
            REG_SRC:    data_o = src_q;
            REG_DST:    data_o = dst_q;
            REG_LEN:    data_o = {{(MemBus-DmaLenW){1'b0}}, len_q};
            REG_CTRL:   data_o[CTRL_IRQ_EN] = irq_en_q;
            REG_STATUS: begin
                data_o[STAT_BUSY] = busy_q;
                data_o[STAT_DONE] = done_q;
                data_o[STAT_ERR]  = err_q;
            end
            default:    data_o = '0;
        endcase
    end

    always_comb begin
        state_n   = state_q;
        src_n     = src_q;
        dst_n     = dst_q;
        len_n     = len_q;
        irq_en_n  = irq_en_q;
        busy_n    = busy_q;
        done_n    = done_q;
        err_n     = err_q;
        cur_src_n = cur_src_q;
        cur_dst_n = cur_dst_q;
        rem_n     = rem_q;
        buf_n     = buf_q;
        m_req_o   = 1'b0;
        m_we_o    = 1'b0;
        m_addr_o  = '0;
        m_data_o  = '0;

        if (!busy_q) begin
            if (wr_src) src_n = data_i;
            if (wr_dst) dst_n = data_i;
            if (wr_len) len_n = data_i[DmaLenW-1:0];
        end
        if (wr_ctrl) irq_en_n = data_i[CTRL_IRQ_EN];
        if (wr_status) begin
            done_n = 1'b0;
            err_n  = 1'b0;
        end

        // FSM updates follow the register writes so completion/error wins
        // over a STATUS clear landing on the same edge.
        case (state_q)
            DMA_IDLE: begin
                if (start_req) begin
                    busy_n    = 1'b1;
                    done_n    = 1'b0;
                    err_n     = 1'b0;
                    cur_src_n = src_q;
                    cur_dst_n = dst_q;
                    rem_n     = len_q;
                    state_n   = (len_q != '0) ? DMA_READ : DMA_FINISH;
                end
            end
            DMA_READ: begin
                if (dma_addr_ok(cur_src_q)) begin
                    m_req_o  = 1'b1;
                    m_addr_o = cur_src_q;
                    buf_n    = m_data_i;
                    state_n  = DMA_WRITE;
                end else begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = DMA_IDLE;
                end
            end
            DMA_WRITE: begin
                if (dma_addr_ok(cur_dst_q)) begin
                    m_req_o   = 1'b1;
                    m_we_o    = 1'b1;
                    m_addr_o  = cur_dst_q;
                    m_data_o  = buf_q;
                    cur_src_n = cur_src_q + 32'd4;
                    cur_dst_n = cur_dst_q + 32'd4;
                    rem_n     = rem_q - 1'b1;
                    state_n   = (rem_q == 16'd1) ? DMA_FINISH : DMA_READ;
                end else begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = DMA_IDLE;
                end
            end
            DMA_FINISH: begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = DMA_IDLE;
            end
            default: state_n = DMA_IDLE;
        endcase

        // Registered from next-state values so irq_o tracks the flags with no extra lag
        irq_n = irq_en_n & (done_n | err_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DMA_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            irq_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            rem_q     <= '0;
            buf_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            src_q     <= src_n;
            dst_q     <= dst_n;
            len_q     <= len_n;
            irq_en_q  <= irq_en_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            err_q     <= err_n;
            cur_src_q <= cur_src_n;
            cur_dst_q <= cur_dst_n;
            rem_q     <= rem_n;
            buf_q     <= buf_n;
            irq_q     <= irq_n;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_rib_dma.sv
// Scoreboard bench for rib_dma: expected bus cycles are queued by the
// stimulus thread and consumed by a negedge monitor on m_req_o.
module tb_rib_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        we_i = 1'b0;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic [31:0] m_data_i;
    logic        m_req_o;
    logic        m_we_o;
    logic        irq_o;

    localparam logic [31:0] A_SRC  = 32'h00;
    localparam logic [31:0] A_DST  = 32'h04;
    localparam logic [31:0] A_LEN  = 32'h08;
    localparam logic [31:0] A_CTRL = 32'h0C;
    localparam logic [31:0] A_STAT = 32'h10;
    localparam logic [31:0] A_NONE = 32'h14;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    bus_t sb[$];
    bus_t exp_b;
    int   checks = 0;
    int   errors = 0;

    rib_dma dut (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .we_i    (we_i),
        .m_addr_o(m_addr_o),
        .m_data_o(m_data_o),
        .m_data_i(m_data_i),
        .m_req_o (m_req_o),
        .m_we_o  (m_we_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    // Slave memory returns a value derived from the address, same cycle
    assign m_data_i = {m_addr_o[15:0], 16'hC0DE};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_req_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bus: got we=%0b addr=%h expected no bus cycle", m_we_o, m_addr_o);
            end else begin
                exp_b = sb.pop_front();
                chk("bus_we", {31'b0, m_we_o}, {31'b0, exp_b.we});
                chk("bus_addr", m_addr_o, exp_b.addr);
                if (exp_b.we) chk("bus_wdata", m_data_o, exp_b.data);
            end
        end
    end

    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d);
        sb.push_back('{we: we, addr: a, data: d});
    endtask

    task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_i = a;
        data_i = d;
        we_i   = 1'b1;
        @(posedge clk);
        #1;
        we_i   = 1'b0;
    endtask

    task automatic cfg_rd(input logic [31:0] a, output logic [31:0] d);
        addr_i = a;
        #1;
        d = data_o;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        int          waited;

        // Reset state
        #2;
        chk("rst_req", {31'b0, m_req_o}, 32'd0);
        chk("rst_irq", {31'b0, irq_o}, 32'd0);
        cfg_rd(A_SRC, r);  chk("rst_src", r, 32'h0);
        cfg_rd(A_LEN, r);  chk("rst_len", r, 32'h0);
        cfg_rd(A_STAT, r); chk("rst_stat", r, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Three-word copy, cycle-exact completion
        cfg_wr(A_SRC, 32'h1000_0000);
        cfg_wr(A_DST, 32'h1000_0100);
        cfg_wr(A_LEN, 32'd3);
        push(1'b0, 32'h1000_0000, 32'h0);
        push(1'b1, 32'h1000_0100, 32'h0000_C0DE);
        push(1'b0, 32'h1000_0004, 32'h0);
        push(1'b1, 32'h1000_0104, 32'h0004_C0DE);
        push(1'b0, 32'h1000_0008, 32'h0);
        push(1'b1, 32'h1000_0108, 32'h0008_C0DE);
        cfg_wr(A_CTRL, 32'h1);
        cfg_rd(A_STAT, r); chk("len3_busy", r, 32'h1);
        cycles(6);
        cfg_rd(A_STAT, r); chk("len3_finish_busy", r, 32'h1);
        cycles(1);
        cfg_rd(A_STAT, r); chk("len3_done", r, 32'h2);
        chk("len3_sb_empty", 32'(sb.size()), 32'd0);
        cfg_rd(A_SRC, r);  chk("len3_src_kept", r, 32'h1000_0000);
        cfg_rd(A_CTRL, r); chk("ctrl_start_reads0", r, 32'h0);

        // Zero length: no bus cycle, done next cycle
        cfg_wr(A_LEN, 32'd0);
        cfg_wr(A_CTRL, 32'h1);
        cfg_rd(A_STAT, r); chk("len0_busy", r, 32'h1);
        cycles(1);
        cfg_rd(A_STAT, r); chk("len0_done", r, 32'h2);

        // Illegal destination region with interrupt enabled
        cfg_wr(A_STAT, 32'h0);
        cfg_wr(A_DST, 32'h7000_0000);
        cfg_wr(A_LEN, 32'd1);
        push(1'b0, 32'h1000_0000, 32'h0);
        cfg_wr(A_CTRL, 32'h3);
        chk("err_irq_low_at_start", {31'b0, irq_o}, 32'd0);
        cycles(2);
        cfg_rd(A_STAT, r); chk("err_dst_status", r, 32'h4);
        chk("err_irq_high", {31'b0, irq_o}, 32'd1);
        cfg_rd(A_CTRL, r); chk("irq_en_readback", r, 32'h2);
        cfg_wr(A_STAT, 32'hFFFF_FFFF);
        chk("err_irq_cleared", {31'b0, irq_o}, 32'd0);
        cfg_rd(A_STAT, r); chk("err_status_cleared", r, 32'h0);

        // SRC write while busy is ignored
        cfg_wr(A_DST, 32'h1000_0200);
        cfg_wr(A_LEN, 32'd2);
        push(1'b0, 32'h1000_0000, 32'h0);
        push(1'b1, 32'h1000_0200, 32'h0000_C0DE);
        push(1'b0, 32'h1000_0004, 32'h0);
        push(1'b1, 32'h1000_0204, 32'h0004_C0DE);
        cfg_wr(A_CTRL, 32'h1);
        cfg_wr(A_SRC, 32'h2000_0000);
        cfg_rd(A_SRC, r); chk("busy_src_ignored", r, 32'h1000_0000);
        waited = 0;
        cfg_rd(A_STAT, r);
        while (r != 32'h2 && waited < 20) begin
            cycles(1);
            waited++;
            cfg_rd(A_STAT, r);
        end
        chk("busy_done", r, 32'h2);
        chk("busy_done_latency", 32'(waited), 32'd4);
        chk("busy_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during the second WRITE of a four-word copy
        cfg_wr(A_DST, 32'h1000_0300);
        cfg_wr(A_LEN, 32'd4);
        push(1'b0, 32'h1000_0000, 32'h0);
        push(1'b1, 32'h1000_0300, 32'h0000_C0DE);
        push(1'b0, 32'h1000_0004, 32'h0);
        cfg_wr(A_CTRL, 32'h1);
        cycles(3);
        chk("pre_rst_req", {30'b0, m_req_o, m_we_o}, 32'h3);
        chk("pre_rst_addr", m_addr_o, 32'h1000_0304);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", {30'b0, m_req_o, m_we_o}, 32'h0);
        chk("rst_mid_addr", m_addr_o, 32'h0);
        cfg_rd(A_SRC, r);  chk("rst_mid_src", r, 32'h0);
        cfg_rd(A_DST, r);  chk("rst_mid_dst", r, 32'h0);
        cfg_rd(A_STAT, r); chk("rst_mid_stat", r, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cycles(10);
        cfg_rd(A_STAT, r); chk("rst_no_partial_done", r, 32'h0);
        chk("rst_sb_empty", 32'(sb.size()), 32'd0);

        // Source walks from region 5 into illegal region 6
        cfg_wr(A_SRC, 32'h5FFF_FFFC);
        cfg_wr(A_DST, 32'h1000_0000);
        cfg_wr(A_LEN, 32'd2);
        push(1'b0, 32'h5FFF_FFFC, 32'h0);
        push(1'b1, 32'h1000_0000, 32'hFFFC_C0DE);
        cfg_wr(A_CTRL, 32'h1);
        cycles(3);
        cfg_rd(A_STAT, r); chk("wrap_region_err", r, 32'h4);
        chk("wrap_irq_disabled", {31'b0, irq_o}, 32'd0);
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Misaligned source rejected before any bus cycle
        cfg_wr(A_STAT, 32'h0);
        cfg_wr(A_SRC, 32'h1000_0002);
        cfg_wr(A_LEN, 32'd1);
        cfg_wr(A_CTRL, 32'h1);
        cycles(1);
        cfg_rd(A_STAT, r); chk("misalign_err", r, 32'h4);

        // Unmapped offset and LEN truncation
        cfg_wr(A_NONE, 32'hFFFF_FFFF);
        cfg_rd(A_NONE, r); chk("unmapped_reads0", r, 32'h0);
        cfg_wr(A_LEN, 32'hABCD_0005);
        cfg_rd(A_LEN, r); chk("len_16bit", r, 32'h0000_0005);

        cycles(2);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
